// File: rtl/iq_pkg.sv
// Shared constants for the I/Q word unpacker: frame pattern, field positions,
// link state encoding and the word pattern check.
package iq_pkg;

   localparam logic [1:0] SYNC_I = 2'b10;
   localparam logic [1:0] SYNC_Q = 2'b01;

   localparam int I_MSB    = 29;
   localparam int I_LSB    = 17;
   localparam int Q_MSB    = 13;
   localparam int Q_LSB    = 1;
   localparam int IQ_RAW_W = 13;

   localparam logic [1:0] LINK_IDLE   = 2'd0;
   localparam logic [1:0] LINK_ACTIVE = 2'd1;
   localparam logic [1:0] LINK_LOST   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = LINK_IDLE,
      ST_ACTIVE = LINK_ACTIVE,
      ST_LOST   = LINK_LOST
   } link_state_e;

   // An all-zero word fails on the I sync bits, so no separate test is needed.
   function automatic logic iq_word_ok(input logic [31:0] w);
      return (w[31:30] == SYNC_I) && !w[16] && (w[15:14] == SYNC_Q) && !w[0];
   endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Small first-word-fall-through FIFO built from a register array.
// The caller must not push when full unless it pops in the same cycle.
module iq_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_comb begin
            mem_d[gi] = mem_q[gi];
            if (push && (wr_ptr_q == PTR_W'(gi)))
               mem_d[gi] = din;
         end

         always_ff @(posedge clk) begin
            mem_q[gi] <= mem_d[gi];
         end
      end
   endgenerate

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push)
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)
         level_d = level_q + LVL_W'(1);
      else if (pop && !push)
         level_d = level_q - LVL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Output forced to zero when empty so it is stable and clean after reset.
   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_W'(DEPTH));
   assign level = level_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/iq_word_unpacker.sv
// Checks aligned I/Q words, sign-extends the samples into a FWFT FIFO and
// tracks link state, overflow drops and format errors.
module iq_word_unpacker
   import iq_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int OUT_W       = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                          i_ddr_clk,
   input  logic                          i_rst,
   input  logic                          i_word_push,
   input  logic [31:0]                   i_word_data,
   output logic                          o_iq_valid,
   input  logic                          i_iq_ready,
   output logic [OUT_W-1:0]              o_i_data,
   output logic [OUT_W-1:0]              o_q_data,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic [1:0]                    o_link_state,
   output logic                          o_overflow,
   output logic                          o_format_err,
   output logic [15:0]                   o_drop_count,
   input  logic                          i_clr_status
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic                  word_ok;
   logic                  word_bad;
   logic [IQ_RAW_W-1:0]   raw_i;
   logic [IQ_RAW_W-1:0]   raw_q;
   logic [2*OUT_W-1:0]    fifo_din;
   logic [2*OUT_W-1:0]    fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic                  fifo_push;
   logic                  drop;

   link_state_e           state_q, state_d;
   logic [CNT_W-1:0]      wdog_q, wdog_d;
   logic                  overflow_q, overflow_d;
   logic                  format_err_q, format_err_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;

   assign word_ok  = i_word_push &&  iq_word_ok(i_word_data);
   assign word_bad = i_word_push && !iq_word_ok(i_word_data);
   assign raw_i    = i_word_data[I_MSB:I_LSB];
   assign raw_q    = i_word_data[Q_MSB:Q_LSB];
   assign fifo_din = {OUT_W'($signed(raw_i)), OUT_W'($signed(raw_q))};

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign fifo_pop  = !fifo_empty && i_iq_ready;
   assign fifo_push = word_ok && (!fifo_full || fifo_pop);
   assign drop      = word_ok && fifo_full && !fifo_pop;

   iq_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*OUT_W)
   ) u_fifo (
      .clk   (i_ddr_clk),
      .srst  (i_rst),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (o_fifo_level)
   );

   // A same-cycle event beats the clear, leaving flag=1 and count=1.
   always_comb begin
      overflow_d   = overflow_q;
      format_err_d = format_err_q;
      drop_cnt_d   = drop_cnt_q;
      if (i_clr_status) begin
         overflow_d   = drop;
         format_err_d = word_bad;
         drop_cnt_d   = drop ? 16'd1 : 16'd0;
      end else begin
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF)
               drop_cnt_d = drop_cnt_q + 16'd1;
         end
         if (word_bad)
            format_err_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      wdog_d  = wdog_q;
      unique case (state_q)
         ST_IDLE, ST_LOST: begin
            wdog_d = '0;
            if (word_ok)
               state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (word_ok) begin
               wdog_d = '0;
            end else if (wdog_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d = ST_LOST;
               wdog_d  = '0;
            end else begin
               wdog_d = wdog_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            wdog_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_ddr_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         wdog_q       <= '0;
         overflow_q   <= 1'b0;
         format_err_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         wdog_q       <= wdog_d;
         overflow_q   <= overflow_d;
         format_err_q <= format_err_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign o_iq_valid   = !fifo_empty;
   assign o_i_data     = fifo_dout[2*OUT_W-1:OUT_W];
   assign o_q_data     = fifo_dout[OUT_W-1:0];
   assign o_link_state = state_q;
   assign o_overflow   = overflow_q;
   assign o_format_err = format_err_q;
   assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_iq_word_unpacker.sv
// Randomized and directed bench for iq_word_unpacker against a queue-based
// reference model derived from the word format and link rules.
module tb_iq_word_unpacker;

   localparam int DEPTH   = 8;
   localparam int OUT_W   = 16;
   localparam int TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              word_push = 1'b0;
   logic [31:0]       word_data = '0;
   logic              iq_valid;
   logic              iq_ready = 1'b0;
   logic [OUT_W-1:0]  i_data;
   logic [OUT_W-1:0]  q_data;
   logic [3:0]        fifo_level;
   logic [1:0]        link_state;
   logic              overflow;
   logic              format_err;
   logic [15:0]       drop_count;
   logic              clr_status = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int   m_fifo_i[$];
   int   m_fifo_q[$];
   int   m_link;
   int   m_since;
   bit   m_ovf;
   bit   m_fmt;
   int   m_drops;

   iq_word_unpacker #(
      .FIFO_DEPTH  (DEPTH),
      .OUT_W       (OUT_W),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .i_ddr_clk    (clk),
      .i_rst        (rst),
      .i_word_push  (word_push),
      .i_word_data  (word_data),
      .o_iq_valid   (iq_valid),
      .i_iq_ready   (iq_ready),
      .o_i_data     (i_data),
      .o_q_data     (q_data),
      .o_fifo_level (fifo_level),
      .o_link_state (link_state),
      .o_overflow   (overflow),
      .o_format_err (format_err),
      .o_drop_count (drop_count),
      .i_clr_status (clr_status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] make_word(input int i13, input int q13);
      logic [31:0] w;
      w = 32'h8000_4000;
      w = w | (32'(i13 & 8191) << 17) | (32'(q13 & 8191) << 1);
      return w;
   endfunction

   function automatic int to_signed13(input logic [31:0] w, input int lsb);
      int v;
      v = int'((w >> lsb) & 32'h1FFF);
      if (v >= 4096) v = v - 8192;
      return v;
   endfunction

   function automatic logic [31:0] to_out(input int v);
      logic [OUT_W-1:0] r;
      r = OUT_W'(v);
      return {16'd0, r};
   endfunction

   task automatic model_reset();
      m_fifo_i.delete();
      m_fifo_q.delete();
      m_link  = 0;
      m_since = 0;
      m_ovf   = 1'b0;
      m_fmt   = 1'b0;
      m_drops = 0;
   endtask

   task automatic model_edge(input bit p, input logic [31:0] w, input bit rdy,
                             input bit clr, input bit r);
      bit ok, pop, dropped;
      if (r) begin
         model_reset();
         return;
      end
      ok      = p && ((w & 32'hC001_C001) == 32'h8000_4000);
      pop     = (m_fifo_i.size() > 0) && rdy;
      dropped = ok && (m_fifo_i.size() == DEPTH) && !pop;
      if (pop) begin
         void'(m_fifo_i.pop_front());
         void'(m_fifo_q.pop_front());
      end
      if (ok && !dropped) begin
         m_fifo_i.push_back(to_signed13(w, 17));
         m_fifo_q.push_back(to_signed13(w, 1));
      end
      if (clr) begin
         m_ovf   = dropped;
         m_fmt   = p && !ok;
         m_drops = dropped ? 1 : 0;
      end else begin
         if (dropped) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
         end
         if (p && !ok) m_fmt = 1'b1;
      end
      if (ok) begin
         m_link  = 1;
         m_since = 0;
      end else if (m_link == 1) begin
         m_since++;
         if (m_since == TIMEOUT) m_link = 2;
      end
   endtask

   task automatic compare_all();
      bit ev;
      ev = (m_fifo_i.size() > 0);
      check("valid", {31'd0, iq_valid}, {31'd0, ev});
      check("level", {28'd0, fifo_level}, 32'(m_fifo_i.size()));
      if (ev) begin
         check("i_data", {16'd0, i_data}, to_out(m_fifo_i[0]));
         check("q_data", {16'd0, q_data}, to_out(m_fifo_q[0]));
      end
      check("link", {30'd0, link_state}, 32'(m_link));
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("format_err", {31'd0, format_err}, {31'd0, m_fmt});
      check("drop_count", {16'd0, drop_count}, 32'(m_drops));
   endtask

   // Inputs are applied at the falling edge, outputs checked at the next one.
   task automatic step(input bit p, input logic [31:0] w, input bit rdy,
                       input bit clr, input bit r);
      word_push  = p;
      word_data  = w;
      iq_ready   = rdy;
      clr_status = clr;
      rst        = r;
      @(posedge clk);
      model_edge(p, w, rdy, clr, r);
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic [31:0] rand_valid();
      return make_word(int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
   endfunction

   int lost_at;

   initial begin
      model_reset();
      @(negedge clk);
      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);
      check("rst_i_data", {16'd0, i_data}, 32'd0);
      check("rst_q_data", {16'd0, q_data}, 32'd0);

      // Single known word into empty FIFO
      step(1, 32'hA000_4002, 0, 0, 0);
      check("t1_i", {16'd0, i_data}, 32'h0000_F000);
      check("t1_q", {16'd0, q_data}, 32'h0000_0001);
      check("t1_level", {28'd0, fifo_level}, 32'd1);
      $display("t1: single word done");

      // Malformed word, then clear
      step(0, '0, 0, 0, 1);
      step(1, 32'hFFFF_FFFF, 0, 0, 0);
      check("t2_fmt", {31'd0, format_err}, 32'd1);
      check("t2_link", {30'd0, link_state}, 32'd0);
      step(1, 32'h0000_0000, 0, 0, 0);
      step(0, '0, 0, 1, 0);
      check("t2_clr", {31'd0, format_err}, 32'd0);
      $display("t2: format error done");

      // Overflow with 10 words into 8 entries, then drain
      step(0, '0, 0, 0, 1);
      for (int k = 0; k < 10; k++) step(1, rand_valid(), 0, 0, 0);
      check("t3_level", {28'd0, fifo_level}, 32'd8);
      check("t3_ovf", {31'd0, overflow}, 32'd1);
      check("t3_drops", {16'd0, drop_count}, 32'd2);
      for (int k = 0; k < 8; k++) step(0, '0, 1, 0, 0);
      check("t3_empty", {31'd0, iq_valid}, 32'd0);
      $display("t3: overflow and drain done");

      // Full FIFO with simultaneous push and pop
      for (int k = 0; k < 8; k++) step(1, rand_valid(), 0, 0, 0);
      step(1, make_word(4095, -4096), 1, 0, 0);
      check("t4_level", {28'd0, fifo_level}, 32'd8);
      check("t4_drops", {16'd0, drop_count}, 32'd2);
      for (int k = 0; k < 8; k++) step(0, '0, 1, 0, 0);
      $display("t4: full push+pop done");

      // Link watchdog
      step(0, '0, 0, 0, 1);
      for (int n = 0; n < 5; n++) begin
         step(1, rand_valid(), 1, 0, 0);
         for (int k = 0; k < 15; k++) step(0, '0, 1, 0, 0);
         check("t5_active", {30'd0, link_state}, 32'd1);
      end
      lost_at = -1;
      for (int k = 16; k <= 80; k++) begin
         step(0, '0, 1, 0, 0);
         if (lost_at < 0 && link_state == 2'd2) lost_at = k;
      end
      check("t5_lost_at", 32'(lost_at), 32'(TIMEOUT));
      step(1, rand_valid(), 1, 0, 0);
      check("t5_relink", {30'd0, link_state}, 32'd1);
      $display("t5: link watchdog done");

      // Reset mid-stream with a same-cycle push
      for (int k = 0; k < 5; k++) step(1, rand_valid(), 0, 0, 0);
      step(1, rand_valid(), 0, 0, 1);
      check("t6_level", {28'd0, fifo_level}, 32'd0);
      check("t6_valid", {31'd0, iq_valid}, 32'd0);
      check("t6_link", {30'd0, link_state}, 32'd0);
      check("t6_drops", {16'd0, drop_count}, 32'd0);
      $display("t6: reset mid-stream done");

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         bit p, rdy, clr, r;
         logic [31:0] w;
         p   = ($urandom_range(0, 3) != 0);
         w   = ($urandom_range(0, 7) == 0) ? $urandom() : rand_valid();
         rdy = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 40) == 0);
         r   = ($urandom_range(0, 400) == 0);
         if (k % 500 > 400) p = 1'b0;
         step(p, w, rdy, clr, r);
      end
      $display("random: 3000 cycles done");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
